// File: rtl/raxi_pkg.sv
// Shared types and helpers for the rAXI elastic buffer.
package raxi_pkg;

  localparam int OVF_CNT_W = 16;
  localparam int RAXI_DW   = 10;
  localparam int RAXI_NCH  = 1;

  // Default-configuration word; parameterized instances size their own.
  typedef logic [RAXI_NCH*RAXI_DW-1:0] raxi_word_t;

  // Pointer width that never collapses to zero bits.
  function automatic int raxi_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raxi_fifo_ctrl.sv
// Pointer, level, full and overflow bookkeeping for raxi_fifo.
// Optional dropped-word counter under RAXI_FIFO_OVF_CNT_EN.
module raxi_fifo_ctrl
  import raxi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = raxi_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic          m_ready,
  input  logic          ovf_clr,
  output logic          wr_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic          m_valid,
  output logic [AW:0]   level,
  output logic          full,
  output logic          ovf
`ifdef RAXI_FIFO_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

  logic rd, wr, drop;

  assign m_valid = (level != '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign rd      = m_valid && m_ready;
  // A read frees a slot in the same cycle, so a full FIFO still accepts.
  assign wr      = s_valid && (!full || rd);
  assign drop    = s_valid && full && !rd;
  assign wr_en   = wr && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A drop coinciding with a clear keeps the flag set.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef RAXI_FIFO_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      ovf_cnt <= '0;
    else if (ovf_clr)
      ovf_cnt <= drop ? OVF_CNT_W'(1) : '0;
    else if (drop && (ovf_cnt != '1))
      ovf_cnt <= ovf_cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/raxi_fifo.sv
// First-word-fall-through elastic buffer from rAXI (no backpressure) to valid/ready.
// Define RAXI_FIFO_OVF_CNT_EN to add the ovf_cnt dropped-word counter port.
module raxi_fifo
  import raxi_pkg::*;
#(
  parameter int DW    = 10,
  parameter int NCH   = 1,
  parameter int DEPTH = 16,
  parameter int AW    = raxi_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [NCH*DW-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [NCH*DW-1:0] m_data,
  output logic [AW:0]       level,
  output logic              full,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef RAXI_FIFO_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

  logic [NCH-1:0][DW-1:0] mem [DEPTH];
  logic                   wr_en;
  logic [AW-1:0]          wr_ptr, rd_ptr;

  raxi_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .m_ready (m_ready),
    .ovf_clr (ovf_clr),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .m_valid (m_valid),
    .level   (level),
    .full    (full),
    .ovf     (ovf)
`ifdef RAXI_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  // Storage is deliberately not reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  assign m_data = mem[rd_ptr];

endmodule

// File: tb/tb_raxi_fifo.sv
// Directed self-checking bench for raxi_fifo (DW=10, NCH=2, DEPTH=4).
module tb_raxi_fifo;

  localparam int DW    = 10;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [NCH*DW-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [NCH*DW-1:0] m_data;
  logic [2:0]        level;
  logic              full;
  logic              ovf;
  logic              ovf_clr;
`ifdef RAXI_FIFO_OVF_CNT_EN
  logic [15:0]       ovf_cnt;
`endif

  int passed = 0;
  int total  = 0;
  logic [NCH*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  raxi_fifo #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level),
    .full    (full),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`ifdef RAXI_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level",   32'(level),   32'd0);
    check("rst_full",    32'(full),    32'd0);
    check("rst_ovf",     32'(ovf),     32'd0);
`ifdef RAXI_FIFO_OVF_CNT_EN
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif

    // single word, fall-through latency
    rst = 1'b0; s_valid = 1'b1; s_data = 20'h155;
    step();
    s_valid = 1'b0;
    check("one_m_valid", 32'(m_valid), 32'd1);
    check("one_m_data",  32'(m_data),  32'h155);
    check("one_level",   32'(level),   32'd1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("one_drained", 32'(level), 32'd0);

    // m_ready with empty FIFO is a no-op
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("empty_rdy_level", 32'(level), 32'd0);

    // fill, then overflow
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = 20'(i);
      step();
    end
    check("fill_full",  32'(full),  32'd1);
    check("fill_level", 32'(level), 32'd4);
    check("fill_ovf",   32'(ovf),   32'd0);
    s_data = 20'd5;
    step();
    s_valid = 1'b0;
    check("drop_ovf",   32'(ovf),   32'd1);
    check("drop_level", 32'(level), 32'd4);
`ifdef RAXI_FIFO_OVF_CNT_EN
    check("drop_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(m_valid), 32'd1);
      check("drain_data",  32'(m_data),  32'(i));
      m_ready = 1'b1;
      step();
    end
    m_ready = 1'b0;
    check("drain_empty", 32'(m_valid), 32'd0);
    check("drain_ovf_sticky", 32'(ovf), 32'd1);

    // clear overflow
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);
`ifdef RAXI_FIFO_OVF_CNT_EN
    check("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif

    // full with simultaneous read and write for 10 cycles
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 20'(10 + i);
      exp_q.push_back(20'(10 + i));
      step();
    end
    check("rw_full", 32'(full), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 20'(20 + i);
      check("rw_data", 32'(m_data), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(20'(20 + i));
      check("rw_level", 32'(level), 32'd4);
    end
    check("rw_ovf", 32'(ovf), 32'd0);
    m_ready = 1'b0;

    // drop coinciding with clear: set wins
    s_data = 20'h3ff; ovf_clr = 1'b1;
    step();
    s_valid = 1'b0; ovf_clr = 1'b0;
    check("clr_drop_ovf", 32'(ovf), 32'd1);
`ifdef RAXI_FIFO_OVF_CNT_EN
    check("clr_drop_cnt", 32'(ovf_cnt), 32'd1);
`endif
    check("clr_drop_head", 32'(m_data), 32'(exp_q[0]));

    // reset mid-operation with level 3
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_level", 32'(level),   32'd0);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_ovf",   32'(ovf),     32'd0);
    s_valid = 1'b1; s_data = 20'd7;
    step();
    s_valid = 1'b0;
    check("post_rst_data",  32'(m_data), 32'd7);
    check("post_rst_level", 32'(level),  32'd1);

    // write during reset is not stored
    rst = 1'b1; s_valid = 1'b1; s_data = 20'd9;
    step();
    rst = 1'b0; s_valid = 1'b0;
    check("rst_wr_level", 32'(level),   32'd0);
    check("rst_wr_valid", 32'(m_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
